vga_frame_driver: RTL

Display-side counterpart to the sprite generators. Produces the 640x480@60 Hz raster position (`xx`, `yy`, `aactive`) and a frame tick that sprite blocks consume. Takes back each sprite's on-flag and 8-bit ROM pixel, composites them over a background colour, and drives pipeline-aligned RGB and sync pins on the Basys 3 VGA connector.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_frame_driver_if.sv | 32 +++
 rtl/pixel_compositor.sv | 50 +++++
 rtl/vga_frame_driver.sv | 101 ++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA frame driver.
//
// Timing: 640x480@60 Hz on a 25 MHz pixel clock.
//   Horizontal: 640 active, 16 front porch, 96 sync, 48 back porch = 800.
//   Vertical:   480 active, 10 front porch,  2 sync, 33 back porch = 525.
// PIPE_DLY is the fixed latency from counter position to the VGA pins.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int PIPE_DLY = 3;

    // 10-bit forms of the counter decode points, so comparisons stay width-matched.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LIMIT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_LIMIT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_TICK_POS   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_TICK_POS   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Both sync lines travel together down the delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // RRRGGGBB -> {R4,G4,B4}. The top bit of each 3-bit field is replicated
    // into the LSB so full scale maps to 4'hF; blue doubles its 2 bits.
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] pix);
        return {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]};
    endfunction

endpackage

// File: rtl/vga_frame_driver_if.sv
// Bundle of raster, sprite-return and VGA pin signals.
//
//   xx, yy, aactive, frame_tick : raster position and decodes (driver -> sprites)
//   sprite_on                   : sprite on-flag, 1 cycle after its position
//   sprite_pix                  : sprite RRRGGGBB pixel, 2 cycles after its position
//   hsync, vsync, rgb           : pipeline-aligned VGA connector pins
//
// Handshake: none. There is no valid/ready pair; every signal is
// meaningful on every Pclk cycle and the receiver samples it unconditionally.
//
// master : the frame driver.   slave : sprite logic / connector side.
interface vga_frame_driver_if;
    logic [9:0]  xx;
    logic [9:0]  yy;
    logic        aactive;
    logic        frame_tick;
    logic        sprite_on;
    logic [7:0]  sprite_pix;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    modport master (
        output xx, yy, aactive, frame_tick, hsync, vsync, rgb,
        input  sprite_on, sprite_pix
    );

    modport slave (
        input  xx, yy, aactive, frame_tick, hsync, vsync, rgb,
        output sprite_on, sprite_pix
    );
endinterface

// File: rtl/pixel_compositor.sv
// Composites one sprite pixel over a flat background colour.
//
// Ports:
//   Pclk, rst_n  : pixel clock, synchronous active-low reset
//   sprite_on    : on-flag, one cycle ahead of sprite_pix
//   sprite_pix   : RRRGGGBB pixel
//   active_d     : active-area flag already delayed to line up with sprite_pix
//   rgb          : registered {R4,G4,B4}
//
// The on-flag is re-delayed one cycle so it meets its own pixel; the
// output register is the final pipeline stage ahead of the pins.
module pixel_compositor
    import vga_pkg::*;
#(
    parameter logic [7:0]  TRANSP = 8'h00,
    parameter logic [11:0] BG_RGB = 12'h000
) (
    input  logic        Pclk,
    input  logic        rst_n,
    input  logic        sprite_on,
    input  logic [7:0]  sprite_pix,
    input  logic        active_d,
    output logic [11:0] rgb
);

    logic        on_d;
    logic [11:0] rgb_next;

    always_comb begin
        rgb_next = 12'h000;
        if (active_d) begin
            if (on_d && (sprite_pix != TRANSP)) begin
                rgb_next = rgb332_to_444(sprite_pix);
            end else begin
                rgb_next = BG_RGB;
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            on_d <= 1'b0;
            rgb  <= 12'h000;
        end else begin
            on_d <= sprite_on;
            rgb  <= rgb_next;
        end
    end

endmodule

// File: rtl/vga_frame_driver.sv
// 640x480@60 Hz raster generator and sprite compositor for the Basys 3 VGA port.
//
// Ports:
//   Pclk   : 25 MHz pixel clock
//   rst_n  : synchronous active-low reset
//   vga    : master side of vga_frame_driver_if (raster out, sprite in, pins out)
//
// Parameters:
//   TRANSP : sprite pixel value treated as transparent
//   BG_RGB : colour shown in the active area behind transparent/absent sprites
//
// Position P appears on xx/yy at cycle t; its hsync/vsync/rgb reach the
// pins at t+PIPE_DLY. Reset parks the counters at the last position of the
// frame so the first released edge lands on (0,0).
module vga_frame_driver
    import vga_pkg::*;
#(
    parameter logic [7:0]  TRANSP = 8'h00,
    parameter logic [11:0] BG_RGB = 12'h000
) (
    input  logic                  Pclk,
    input  logic                  rst_n,
    vga_frame_driver_if.master    vga
);

    logic [9:0] xx_q;
    logic [9:0] yy_q;
    logic       active;
    logic       tick;
    sync_t      sync_raw;

    // Sync delay line: all PIPE_DLY stages.
    sync_t      sync_pipe [PIPE_DLY];
    // Active delay line: the compositor's output register acts as the last
    // stage, so only PIPE_DLY-1 stages are kept here.
    logic [PIPE_DLY-2:0] act_pipe;

    logic [11:0] rgb_q;

    // Raster counters; both wrap together at (799,524) -> (0,0).
    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            xx_q <= H_LAST;
            yy_q <= V_LAST;
        end else if (xx_q == H_LAST) begin
            xx_q <= 10'd0;
            yy_q <= (yy_q == V_LAST) ? 10'd0 : yy_q + 10'd1;
        end else begin
            xx_q <= xx_q + 10'd1;
        end
    end

    always_comb begin
        active         = (xx_q < H_ACT_LIMIT) && (yy_q < V_ACT_LIMIT);
        tick           = (xx_q == H_TICK_POS) && (yy_q == V_TICK_POS);
        sync_raw.hsync = !((xx_q >= H_SYNC_FIRST) && (xx_q <= H_SYNC_LAST));
        sync_raw.vsync = !((yy_q >= V_SYNC_FIRST) && (yy_q <= V_SYNC_LAST));
    end

    // Clearing to the idle level on reset means a pulse in flight is dropped,
    // never stretched; pulses resume only from their counter positions.
    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                sync_pipe[i] <= '1;
            end
            act_pipe <= '0;
        end else begin
            sync_pipe[0] <= sync_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
            if (PIPE_DLY > 2) begin
                act_pipe <= {act_pipe[PIPE_DLY-3:0], active};
            end else begin
                act_pipe <= active;
            end
        end
    end

    pixel_compositor #(
        .TRANSP (TRANSP),
        .BG_RGB (BG_RGB)
    ) u_comp (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .sprite_on  (vga.sprite_on),
        .sprite_pix (vga.sprite_pix),
        .active_d   (act_pipe[PIPE_DLY-2]),
        .rgb        (rgb_q)
    );

    assign vga.xx         = xx_q;
    assign vga.yy         = yy_q;
    assign vga.aactive    = active;
    assign vga.frame_tick = tick;
    assign vga.hsync      = sync_pipe[PIPE_DLY-1].hsync;
    assign vga.vsync      = sync_pipe[PIPE_DLY-1].vsync;
    assign vga.rgb        = rgb_q;

endmodule
